// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_if
// Purpose : Load/store request and response bundle between core and dmem_responder.
// Rev     : 1.0
// ============================================================================
interface dmem_responder_if;
  logic        mrd;
  logic        mwrt;
  logic [2:0]  func3;
  logic [31:0] in_addr;
  logic [31:0] w_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] r_data;
  logic        err;

  modport master (
    output mrd, mwrt, func3, in_addr, w_data,
    input  req_ready, rsp_valid, r_data, err
  );

  modport slave (
    input  mrd, mwrt, func3, in_addr, w_data,
    output req_ready, rsp_valid, r_data, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Fixed-latency data memory serving one load/store at a time.
// Rev     : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept_w;
  logic          commit_w;
  logic          f3_ok_w;
  logic          misalign_w;
  logic          range_w;
  logic          err_w;
  logic [AW-1:0] idx_w;
  logic [1:0]    lane_w;
  logic [31:0]   word_w;
  logic [7:0]    byte_w;
  logic [15:0]   half_w;
  logic [31:0]   load_w;
  logic [3:0]    be_w;
  logic [31:0]   wr_word_w;

  assign accept_w = (bus.mrd | bus.mwrt) && (state_q == S_IDLE);
  // RESP is the last busy cycle; the edge leaving it commits and raises the response.
  assign commit_w = (state_q == S_RESP);
  assign idx_w    = addr_q[AW+1:2];
  assign lane_w   = addr_q[1:0];
  assign word_w   = mem_q[idx_w];
  assign byte_w   = word_w[{lane_w, 3'b000} +: 8];
  assign half_w   = lane_w[1] ? word_w[31:16] : word_w[15:0];

  always_comb begin : decode
    f3_ok_w    = 1'b0;
    misalign_w = 1'b0;
    load_w     = word_w;
    be_w       = 4'b1111;
    wr_word_w  = wdata_q;
    case (f3_q)
      3'b000, 3'b001, 3'b010: f3_ok_w = 1'b1;
      3'b100, 3'b101:         f3_ok_w = ~wr_q;
      default:                f3_ok_w = 1'b0;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        load_w    = f3_q[2] ? {24'b0, byte_w} : {{24{byte_w[7]}}, byte_w};
        be_w      = 4'b0001 << lane_w;
        wr_word_w = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        misalign_w = addr_q[0];
        load_w     = f3_q[2] ? {16'b0, half_w} : {{16{half_w[15]}}, half_w};
        be_w       = lane_w[1] ? 4'b1100 : 4'b0011;
        wr_word_w  = {2{wdata_q[15:0]}};
      end
      default: misalign_w = (addr_q[1:0] != 2'b00);
    endcase
  end

  assign range_w = |(addr_q >> (AW + 2));
  assign err_w   = (rd_q & wr_q) | ~f3_ok_w | misalign_w | range_w;

  always_ff @(posedge clk_i) begin : mem_write
    if (commit_w && wr_q && !err_w && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_w[b]) begin
          mem_q[idx_w][8*b +: 8] <= wr_word_w[8*b +: 8];
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    r_data_d    = r_data_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          rd_d    = bus.mrd;
          wr_d    = bus.mwrt;
          f3_d    = bus.func3;
          addr_d  = bus.in_addr;
          wdata_d = bus.w_data;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        err_d       = err_w;
        r_data_d    = (rd_q && !err_w) ? load_w : 32'h0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : regs
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      r_data_q    <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      r_data_q    <= r_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.r_data    = r_data_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Self-checking bench for dmem_responder against a byte-level memory model.
// Rev     : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors;
  int   miss;

  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if if1 ();
  dmem_responder_if if15 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1))   dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15))  dut15 (.clk_i(clk), .rst_i(rst), .bus(if15));

  // Memory seen as little-endian bytes; only bytes written through the model are ever loaded.
  logic [7:0] ref_b [longint];

  function automatic void ref_access(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rdat, output logic e);
    int     n;
    bit     ok_f3;
    longint v;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok_f3 = (rd && !wr) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    e     = (rd && wr) || !ok_f3 || ((a % n) != 0) || (a >= 4 * DEPTH);
    rdat  = 32'h0;
    if (e) return;
    if (wr) begin
      for (int i = 0; i < n; i++) ref_b[longint'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = n - 1; i >= 0; i--) v = (v << 8) | longint'(ref_b[longint'(a) + i]);
      if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      rdat = v[31:0];
    end
  endfunction

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic rdy, output logic [31:0] rdat, output logic e, output int lat);
    @(negedge clk);
    rdy         = bus.req_ready;
    bus.mrd     = rd;
    bus.mwrt    = wr;
    bus.func3   = f3;
    bus.in_addr = a;
    bus.w_data  = wd;
    @(posedge clk);
    #1;
    bus.mrd     = 1'b0;
    bus.mwrt    = 1'b0;
    bus.func3   = 3'($urandom);
    bus.in_addr = $urandom;
    bus.w_data  = $urandom;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdat = bus.r_data;
    e    = bus.err;
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst     = 1'b1;
    bus.mrd = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.r_data !== 32'h0 || bus.err !== 1'b0) begin
      miss++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b, want 1 0 00000000 0",
               bus.req_ready, bus.rsp_valid, bus.r_data, bus.err);
    end
    bus.mrd = 1'b0;
    rst     = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    vectors++;
    if (seen) begin
      miss++;
      $display("FAIL reset_ignores_req: got a response, want none");
    end
  endtask

  task automatic test_directed();
    logic rdy, e;
    logic [31:0] d;
    int lat;
    vec_t t [8] = '{
      '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "SW_10"},
      '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "LW_10"},
      '{1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0,        1'b0, "SB_11"},
      '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADA5EF, 1'b0, "LW_10_merged"},
      '{1'b1, 1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFA5, 1'b0, "LB_11"},
      '{1'b1, 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000A5, 1'b0, "LBU_11"},
      '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, "LH_12"},
      '{1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, "LHU_12"}
    };
    foreach (t[i]) begin
      do_req(t[i].rd, t[i].wr, t[i].f3, t[i].a, t[i].wd, rdy, d, e, lat);
      vectors++;
      if (rdy !== 1'b1 || lat !== LAT || e !== t[i].exp_e || d !== t[i].exp_d) begin
        miss++;
        $display("FAIL %s: got rdy=%b lat=%0d err=%b rdata=%h, want rdy=1 lat=%0d err=%b rdata=%h",
                 t[i].name, rdy, lat, e, d, LAT, t[i].exp_e, t[i].exp_d);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.r_data !== t[i].exp_d) begin
        miss++;
        $display("FAIL %s_pulse_hold: got vld=%b rdata=%h, want vld=0 rdata=%h",
                 t[i].name, bus.rsp_valid, bus.r_data, t[i].exp_d);
      end
    end
  endtask

  task automatic test_errors();
    logic rdy, e;
    logic [31:0] d;
    int lat;
    vec_t t [8] = '{
      '{1'b1, 1'b0, 3'b010, 32'h13,   32'h0,        32'h0,        1'b1, "LW_misaligned"},
      '{1'b0, 1'b1, 3'b001, 32'h11,   32'h0000FFFF, 32'h0,        1'b1, "SH_misaligned"},
      '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADA5EF, 1'b0, "LW_10_unchanged"},
      '{1'b1, 1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, "LW_out_of_range"},
      '{1'b1, 1'b0, 3'b001, 32'h13,   32'h0,        32'h0,        1'b1, "LH_misaligned"},
      '{1'b1, 1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, "L_func3_011"},
      '{1'b0, 1'b1, 3'b100, 32'h10,   32'h11111111, 32'h0,        1'b1, "S_func3_100"},
      '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADA5EF, 1'b0, "LW_10_still"}
    };
    foreach (t[i]) begin
      do_req(t[i].rd, t[i].wr, t[i].f3, t[i].a, t[i].wd, rdy, d, e, lat);
      vectors++;
      if (rdy !== 1'b1 || lat !== LAT || e !== t[i].exp_e || d !== t[i].exp_d) begin
        miss++;
        $display("FAIL %s: got rdy=%b lat=%0d err=%b rdata=%h, want rdy=1 lat=%0d err=%b rdata=%h",
                 t[i].name, rdy, lat, e, d, LAT, t[i].exp_e, t[i].exp_d);
      end
    end
  endtask

  task automatic test_hold_both();
    int acc  = -1;
    int nrsp = 0;
    logic rdy, e;
    logic [31:0] d;
    int lat;
    @(negedge clk);
    bus.mrd     = 1'b1;
    bus.mwrt    = 1'b1;
    bus.func3   = 3'b010;
    bus.in_addr = 32'h10;
    bus.w_data  = 32'h0BADF00D;
    for (int c = 0; c < 16; c++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) begin
        if (acc >= 0) begin
          vectors++;
          if (c - acc !== LAT + 1) begin
            miss++;
            $display("FAIL hold_accept_spacing: got %0d, want %0d", c - acc, LAT + 1);
          end
        end
        acc = c;
      end
      #1;
      if (bus.rsp_valid === 1'b1 && acc >= 0) begin
        nrsp++;
        vectors++;
        if (c - acc !== LAT || bus.err !== 1'b1 || bus.r_data !== 32'h0) begin
          miss++;
          $display("FAIL hold_response: got delay=%0d err=%b rdata=%h, want %0d 1 00000000",
                   c - acc, bus.err, bus.r_data, LAT);
        end
      end
      @(negedge clk);
      bus.in_addr = 32'($urandom_range(0, 31)) << 2;
      bus.w_data  = $urandom;
    end
    bus.mrd  = 1'b0;
    bus.mwrt = 1'b0;
    vectors++;
    if (nrsp < 4) begin
      miss++;
      $display("FAIL hold_response_count: got %0d, want at least 4", nrsp);
    end
    repeat (4) @(posedge clk);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdy, d, e, lat);
    vectors++;
    if (e !== 1'b0 || d !== 32'hDEADA5EF) begin
      miss++;
      $display("FAIL hold_mem_unchanged: got err=%b rdata=%h, want 0 deada5ef", e, d);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, e;
    logic [31:0] d;
    int lat;
    bit seen = 0;
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rdy, d, e, lat);
    vectors++;
    if (e !== 1'b0 || lat !== LAT) begin
      miss++;
      $display("FAIL rstmid_prewrite: got err=%b lat=%0d, want 0 %0d", e, lat, LAT);
    end
    @(negedge clk);
    bus.mrd     = 1'b0;
    bus.mwrt    = 1'b1;
    bus.func3   = 3'b010;
    bus.in_addr = 32'h20;
    bus.w_data  = 32'h12345678;
    @(posedge clk);
    #1;
    bus.mwrt = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.r_data !== 32'h0 || bus.err !== 1'b0) begin
      miss++;
      $display("FAIL rstmid_outputs: got rdy=%b vld=%b rdata=%h err=%b, want 1 0 00000000 0",
               bus.req_ready, bus.rsp_valid, bus.r_data, bus.err);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    vectors++;
    if (seen || bus.req_ready !== 1'b1) begin
      miss++;
      $display("FAIL rstmid_no_response: got seen=%0d rdy=%b, want 0 1", seen, bus.req_ready);
    end
    do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdy, d, e, lat);
    vectors++;
    if (e !== 1'b0 || d !== 32'hCAFEF00D) begin
      miss++;
      $display("FAIL rstmid_store_dropped: got err=%b rdata=%h, want 0 cafef00d", e, d);
    end
  endtask

  task automatic test_random();
    logic rdy, e, exp_e, rd, wr;
    logic [31:0] d, exp_d, a, wd;
    logic [2:0] f3;
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int lat, k;
    for (int w = 0; w < 32; w++) begin
      wd = $urandom;
      ref_access(1'b0, 1'b1, 3'b010, 32'(w * 4), wd, exp_d, exp_e);
      do_req(1'b0, 1'b1, 3'b010, 32'(w * 4), wd, rdy, d, e, lat);
      vectors++;
      if (e !== exp_e || lat !== LAT) begin
        miss++;
        $display("FAIL rand_init w%0d: got err=%b lat=%0d, want %b %0d", w, e, lat, exp_e, LAT);
      end
    end
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 19);
      rd = (k < 9) || (k >= 18);
      wr = (k >= 9);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
      a  = ($urandom_range(0, 9) == 0) ? (32'h1000 | $urandom) : 32'($urandom_range(0, 127));
      wd = $urandom;
      ref_access(rd, wr, f3, a, wd, exp_d, exp_e);
      do_req(rd, wr, f3, a, wd, rdy, d, e, lat);
      vectors++;
      if (rdy !== 1'b1 || lat !== LAT || e !== exp_e || d !== exp_d) begin
        miss++;
        $display("FAIL rand_%0d rd=%b wr=%b f3=%0d a=%h: got rdy=%b lat=%0d err=%b rdata=%h, want 1 %0d %b %h",
                 n, rd, wr, f3, a, rdy, lat, e, d, LAT, exp_e, exp_d);
      end
    end
  endtask

  task automatic test_latency_sweep();
    int acc1 = -1, acc15 = -1, n1 = 0, n15 = 0;
    logic r1, r15;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      r1  = if1.req_ready;
      r15 = if15.req_ready;
      @(posedge clk);
      if (r1) begin
        if (acc1 >= 0) begin
          vectors++;
          if (c - acc1 !== 2) begin
            miss++;
            $display("FAIL sweep_l1_spacing: got %0d, want 2", c - acc1);
          end
        end
        acc1 = c;
      end
      if (r15) begin
        if (acc15 >= 0) begin
          vectors++;
          if (c - acc15 !== 16) begin
            miss++;
            $display("FAIL sweep_l15_spacing: got %0d, want 16", c - acc15);
          end
        end
        acc15 = c;
      end
      #1;
      if (if1.rsp_valid === 1'b1 && acc1 >= 0) begin
        n1++;
        vectors++;
        if (c - acc1 !== 1 || if1.err !== 1'b1) begin
          miss++;
          $display("FAIL sweep_l1_delay: got %0d err=%b, want 1 1", c - acc1, if1.err);
        end
      end
      if (if15.rsp_valid === 1'b1 && acc15 >= 0) begin
        n15++;
        vectors++;
        if (c - acc15 !== 15 || if15.err !== 1'b1) begin
          miss++;
          $display("FAIL sweep_l15_delay: got %0d err=%b, want 15 1", c - acc15, if15.err);
        end
      end
    end
    vectors++;
    if (n1 < 45 || n15 < 5) begin
      miss++;
      $display("FAIL sweep_counts: got l1=%0d l15=%0d, want >=45 >=5", n1, n15);
    end
  endtask

  initial begin
    vectors      = 0;
    miss         = 0;
    rst          = 1'b1;
    bus.mrd      = 1'b0;
    bus.mwrt     = 1'b0;
    bus.func3    = 3'd0;
    bus.in_addr  = 32'h0;
    bus.w_data   = 32'h0;
    if1.mrd      = 1'b1;
    if1.mwrt     = 1'b1;
    if1.func3    = 3'b010;
    if1.in_addr  = 32'h0;
    if1.w_data   = 32'h0;
    if15.mrd     = 1'b1;
    if15.mwrt    = 1'b1;
    if15.func3   = 3'b010;
    if15.in_addr = 32'h0;
    if15.w_data  = 32'h0;
    test_reset();
    test_directed();
    test_errors();
    test_hold_both();
    test_reset_mid();
    test_random();
    test_latency_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
